// File: rtl/isa_dma_pkg.sv
// Shared types and constants for the ISA DMA sequencer: FSM states, config
// register addresses and mode-register field offsets.
package isa_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        FETCH,
        SETUP,
        STROBE,
        HOLD,
        POST,
        DONE
    } dma_state_e;

    localparam logic [2:0] CFG_CNT0 = 3'd0;
    localparam logic [2:0] CFG_CNT1 = 3'd1;
    localparam logic [2:0] CFG_CNT2 = 3'd2;
    localparam logic [2:0] CFG_CNT3 = 3'd3;
    localparam logic [2:0] CFG_MODE = 3'd4;
    localparam logic [2:0] CFG_STAT = 3'd5;

    localparam int MODE_EN_OFS   = 0;
    localparam int MODE_DIR_OFS  = 4;
    localparam int MODE_AUTO_OFS = 8;
    localparam int MODE_W        = 12;

    localparam int TMR_W = 8;

endpackage

// File: rtl/isa_dma_rr_arbiter.sv
// Combinational rotating-priority picker: first eligible channel at or after
// the pointer, wrapping at the last channel.
module isa_dma_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              valid
);

    logic [CH_W-1:0] idx;

    always_comb begin
        grant = ptr;
        valid = 1'b0;
        idx   = '0;
        // Scan farthest-first so the channel closest to ptr is the one that sticks.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (elig[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/isa_dma_sequencer.sv
// Single-transfer ISA DMA sequencer: arbitrates DRQs, borrows the ISA bus from
// the CPU-cycle machine and runs one timed DACK/AEN/strobe cycle per grant.
module isa_dma_sequencer
    import isa_dma_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 6,
    parameter int T_HOLD   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] drq,
    input  logic              bus_idle,
    output logic              bus_hold,
    output logic [NUM_CH-1:0] dack_n,
    output logic              aen,
    output logic              ior_n,
    output logic              iow_n,
    output logic              dma_drive,
    output logic              dma_latch,
    output logic              dma_req,
    output logic              dma_dir,
    output logic [1:0]        dma_ch,
    input  logic              dma_ack,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic [15:0]       cfg_rdata,
    output logic [NUM_CH-1:0] tc
);

    localparam int CH_W = 2;

    dma_state_e                     state_q, state_d;
    logic [TMR_W-1:0]               tmr_q, tmr_d;
    logic [CH_W-1:0]                ch_q, ch_d, ptr_q, ptr_d;
    logic                           dir_q, dir_d;
    logic [NUM_CH-1:0]              meta_q, sync_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   cur_q, cur_d, base_q, base_d;
    logic [MODE_W-1:0]              mode_q, mode_d;
    logic [NUM_CH-1:0]              tc_q, tc_d, tc_set, tc_clr, en_clr;
    logic [NUM_CH-1:0]              en_vec, dir_vec, auto_vec, elig;
    logic [CH_W-1:0]                grant;
    logic                           grant_valid, busy, in_cycle;

    assign en_vec   = mode_q[MODE_EN_OFS   +: NUM_CH];
    assign dir_vec  = mode_q[MODE_DIR_OFS  +: NUM_CH];
    assign auto_vec = mode_q[MODE_AUTO_OFS +: NUM_CH];
    assign elig     = sync_q & en_vec;

    isa_dma_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .elig  (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        base_d  = base_q;
        mode_d  = mode_q;
        tc_set  = '0;
        tc_clr  = '0;
        en_clr  = '0;
        case (state_q)
            IDLE: if (|elig && bus_idle) state_d = ARB;
            ARB: begin
                if (!bus_idle || !grant_valid) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = grant;
                    dir_d   = dir_vec[grant];
                    tmr_d   = '0;
                    state_d = dir_vec[grant] ? FETCH : SETUP;
                end
            end
            FETCH: if (dma_ack) begin
                tmr_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(T_SETUP - 1)) begin
                    tmr_d   = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(T_STROBE - 1)) begin
                    tmr_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(T_HOLD - 1)) begin
                    tmr_d   = '0;
                    state_d = dir_q ? DONE : POST;
                end
            end
            POST: if (dma_ack) state_d = DONE;
            DONE: begin
                if (cur_q[ch_q] == '0) begin
                    tc_set[ch_q] = 1'b1;
                    if (auto_vec[ch_q]) cur_d[ch_q] = base_q[ch_q];
                    else                en_clr[ch_q] = 1'b1;
                end else begin
                    cur_d[ch_q] = cur_q[ch_q] - CNT_W'(1);
                end
                ptr_d   = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mode_d[MODE_EN_OFS +: NUM_CH] = en_vec & ~en_clr;

        // Config writes are applied last so they override a same-cycle DONE update.
        if (cfg_wr) begin
            if (int'(cfg_addr) < NUM_CH) begin
                base_d[cfg_addr[CH_W-1:0]] = CNT_W'(cfg_wdata);
                cur_d[cfg_addr[CH_W-1:0]]  = CNT_W'(cfg_wdata);
            end else if (cfg_addr == CFG_MODE) begin
                mode_d = cfg_wdata[MODE_W-1:0];
            end else if (cfg_addr == CFG_STAT) begin
                tc_clr = cfg_wdata[NUM_CH-1:0];
            end
        end
        tc_d = (tc_q & ~tc_clr) | tc_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            ptr_q   <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
            cur_q   <= '0;
            base_q  <= '0;
            mode_q  <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            ptr_q   <= ptr_d;
            meta_q  <= drq;
            sync_q  <= meta_q;
            cur_q   <= cur_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    // Bus outputs decode straight from registered state, so an async reset
    // returns them to idle levels without waiting for a clock.
    always_comb begin
        busy      = (state_q != IDLE);
        in_cycle  = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
        bus_hold  = busy;
        aen       = in_cycle;
        dack_n    = '1;
        if (in_cycle) dack_n[ch_q] = 1'b0;
        ior_n     = !((state_q == STROBE) && !dir_q);
        iow_n     = !((state_q == STROBE) && dir_q);
        dma_drive = in_cycle && dir_q;
        dma_latch = (state_q == STROBE) && !dir_q && (tmr_q == TMR_W'(T_STROBE - 1));
        dma_req   = (state_q == FETCH) || (state_q == POST);
        dma_dir   = dir_q;
        dma_ch    = ch_q;
        tc        = tc_q;
    end

    always_comb begin
        cfg_rdata = '0;
        if (int'(cfg_addr) < NUM_CH)  cfg_rdata = 16'(cur_q[cfg_addr[CH_W-1:0]]);
        else if (cfg_addr == CFG_MODE) cfg_rdata = 16'(mode_q);
        else if (cfg_addr == CFG_STAT) cfg_rdata = 16'({busy, ch_q, tc_q});
    end

endmodule

// File: doc/isa_dma_sequencer.md
Name: isa_dma_sequencer

Overview:
- Single-transfer ISA DMA controller for the riser bus bridge.
- Arbitrates DRQ1/3/5/7 (ch0..ch3) with rotating priority, and takes the ISA bus from the CPU-cycle state machine through a bus_hold/bus_idle handshake.
- Drives DACK, AEN and the DMA IOR/IOW strobes with programmable timing.
- Per-channel transfer counters raise a terminal count (TC). Data movement to the HPS is paced by a req/ack handshake.

Parameters:
- NUM_CH, 4, number of DMA channels.
- CNT_W, 16, transfer counter width.
- T_SETUP, 2, clk cycles from AEN/DACK assertion to strobe assertion (≥1).
- T_STROBE, 6, clk cycles the IOR/IOW strobe is low (≥1).
- T_HOLD, 1, clk cycles DACK/AEN are held after the strobe is released (≥1).

Ports:
- clk in 1: bus clock.
- reset in 1: asynchronous, active-low reset.
- drq in NUM_CH: raw ISA DRQ, asynchronous to clk.
- bus_idle in 1: CPU-cycle state machine is idle.
- bus_hold out 1: forbids the CPU-cycle state machine from starting a cycle.
- dack_n out NUM_CH: ISA DACK, active-low.
- aen out 1: ISA AEN.
- ior_n out 1: DMA I/O read strobe, active-low.
- iow_n out 1: DMA I/O write strobe, active-low.
- dma_drive out 1: enables the bridge to drive D (mem→I/O).
- dma_latch out 1: one-cycle pulse to capture D (I/O→mem).
- dma_req out 1: HPS data request.
- dma_dir out 1: 0 = I/O→mem, 1 = mem→I/O (valid while dma_req is high).
- dma_ch out 2: active channel.
- dma_ack in 1: HPS handshake completion.
- cfg_wr in 1: configuration write.
- cfg_addr in 3: configuration address.
- cfg_wdata in 16: configuration write data.
- cfg_rdata out 16: configuration read data.
- tc out NUM_CH: sticky terminal-count flags.

Behaviour:
- Reset values (asynchronous): dack_n = all 1s, aen = 0, ior_n = 1, iow_n = 1, bus_hold = 0, dma_drive = 0, dma_latch = 0, dma_req = 0, dma_ch = 0, tc = 0, all counts/bases/mode = 0, priority pointer = ch0, state = IDLE.
- DRQ input: two-flop synchronizer on each drq bit.
- Eligibility: a channel is eligible when its synced drq = 1 and its enable bit = 1.
- Register map (writes):
  - Addr 0..3: base[ch] = cur[ch] = wdata.
  - Addr 4: mode; [3:0] enable, [7:4] dir, [11:8] autoinit.
  - Addr 5: write-1-to-clear tc.
- Register map (reads, combinational): addr 0..3 → cur[ch]; addr 4 → mode; addr 5 → {9'b0, busy, dma_ch, tc}; addr 6..7 → 0.
- FSM:
  - IDLE: if any channel is eligible and bus_idle = 1 → ARB; set bus_hold = 1.
  - ARB: pick the first eligible channel at or after the priority pointer (wrap at NUM_CH-1) and latch ch/dir.
    - If bus_idle = 0 → IDLE and drop bus_hold.
    - Else if dir = 1 → FETCH.
    - Else → SETUP.
  - FETCH: dma_req = 1 until dma_ack = 1, then → SETUP.
  - SETUP (T_SETUP cycles): aen = 1, dack_n[ch] = 0; dma_drive = 1 if dir = 1.
  - STROBE (T_STROBE cycles): ior_n = 0 (dir = 0) or iow_n = 0 (dir = 1). dma_latch pulses on the last STROBE cycle when dir = 0.
  - HOLD (T_HOLD cycles): strobes high; aen, dack and dma_drive held.
  - Leaving HOLD: aen = 0 and dack_n = all 1s.
    - dir = 0 → POST.
    - dir = 1 → DONE.
  - POST: dma_req = 1 until dma_ack = 1, then → DONE.
  - DONE (1 cycle):
    - If cur[ch] == 0: set tc[ch]. If autoinit[ch], cur = base; else clear enable[ch].
    - Otherwise cur[ch] decrements by 1 (no wrap below 0).
    - Priority pointer = ch + 1 (mod NUM_CH). bus_hold = 0. → IDLE.
- Loading count N gives N+1 transfers.
- busy = 1 in every state except IDLE.
- Single transfer per grant: IDLE lasts ≥1 cycle between grants, so the CPU state machine can claim the bus.
- Channel selection is sampled only in ARB. DRQ dropping or the enable bit clearing after ARB does not abort the cycle; the counter still updates in DONE.
- Simultaneous cfg write to cur[ch]/mode and a DONE update of the same channel: the cfg write wins.
- Simultaneous tc clear and tc set on the same bit: the set wins.
- Reset asserted mid-cycle: all outputs return to reset values immediately.

Decomposition:
- Shared package isa_dma_pkg holds:
  - FSM state enum: IDLE, ARB, FETCH, SETUP, STROBE, HOLD, POST, DONE.
  - cfg address constants: CFG_CNT0..3 = 0..3, CFG_MODE = 4, CFG_STAT = 5.
  - Mode field offsets.
- One sub-module: isa_dma_rr_arbiter. Inputs: eligibility vector and pointer. Outputs: grant index and valid. Combinational rotating priority.

Test Plan:
- Mode = 0x0001, cnt0 = 0, drq[0] = 1, bus_idle = 1 → dack_n = 1110 and aen = 1 for 2+6+1 cycles; ior_n low 6 cycles; dma_latch pulses once; dma_req is held until ack; tc = 0001; enable[0] clears; cfg read addr 4 returns 0x0000.
- Mode = 0x00F2 (ch1 enabled, dir = 1), cnt1 = 2, drq[1] held, ack 3 cycles after each req → 3 FETCH→iow_n cycles; dma_drive high over SETUP..HOLD; tc[1] sets after the 3rd transfer; no 4th grant.
- drq = 1111, all channels enabled, dir = 0, counts = 0xFFFF, ack immediate → grants in order ch0, ch1, ch2, ch3, ch0; an IDLE cycle with bus_hold = 0 between grants.
- bus_idle = 0 while drq[2] is eligible → stays in IDLE, dack_n = 1111. bus_idle dropping during ARB → returns to IDLE with no strobe.
- Autoinit on ch3, base = 1 → after 2 transfers tc[3] = 1 and cur3 reloads to 1. Write 0x0008 to addr 5 in the same cycle as a new TC → tc[3] remains 1.
- Reset pulled low during STROBE → ior_n, aen, dack_n and bus_hold are at reset values before the next clk edge; counts read 0.
